// File: rtl/pong_pkg.sv
// Shared types and default geometry for the pong game controller.
//   game_state_t : top-level game FSM encoding (also the game_state output)
//   dir_t        : axis direction, POS = right/down, NEG = left/up
//   *_DEF        : default screen/object geometry
//   sat_inc      : 4-bit saturating score increment
//   cnt_width    : serve counter width, never below 6 bits
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SERVE    = 3'd1,
    ST_PLAY     = 3'd2,
    ST_POINT    = 3'd3,
    ST_GAMEOVER = 3'd4
  } game_state_t;

  typedef enum logic {
    DIR_POS = 1'b0,
    DIR_NEG = 1'b1
  } dir_t;

  localparam int H_ACTIVE_DEF  = 640;
  localparam int V_ACTIVE_DEF  = 480;
  localparam int BALL_SIZE_DEF = 8;
  localparam int PADDLE_H_DEF  = 64;

  localparam int BALL_X_CENTRE = (H_ACTIVE_DEF - BALL_SIZE_DEF) / 2;
  localparam int BALL_Y_CENTRE = (V_ACTIVE_DEF - BALL_SIZE_DEF) / 2;
  localparam int PADDLE_Y_CENTRE = (V_ACTIVE_DEF - PADDLE_H_DEF) / 2;

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s == 4'hF) ? s : s + 4'd1;
  endfunction

  function automatic int cnt_width(input int frames);
    int w;
    w = $clog2(frames);
    return (w < 6) ? 6 : w;
  endfunction

endpackage

// File: rtl/pong_paddle_mover.sv
// One paddle's vertical position register with step and clamp.
//   clk, rst_n : clock, asynchronous active-low reset
//   move_en    : apply one step this cycle (paddle phase of a frame update)
//   up, down   : synchronized buttons; both or neither pressed holds
//   y          : paddle top row, clamped to [0, Y_MAX]
module pong_paddle_mover #(
  parameter int STEP    = 4,
  parameter int Y_MAX   = 416,
  parameter int Y_RESET = 208
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       move_en,
  input  logic       up,
  input  logic       down,
  output logic [9:0] y
);

  localparam logic [9:0] C_STEP  = 10'(STEP);
  localparam logic [9:0] C_MAX   = 10'(Y_MAX);
  localparam logic [9:0] C_RESET = 10'(Y_RESET);

  logic [9:0] y_next;

  // Comparisons are ordered so the subtraction never wraps below zero.
  always_comb begin
    y_next = y;
    if (up && !down) begin
      y_next = (y >= C_STEP) ? y - C_STEP : 10'd0;
    end else if (down && !up) begin
      y_next = (y + C_STEP >= C_MAX) ? C_MAX : y + C_STEP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y <= C_RESET;
    end else if (move_en) begin
      y <= y_next;
    end
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// Frame-rate pong game controller.
//   clk, rst_n          : clock, asynchronous active-low reset
//   frame_tick          : one-cycle pulse per frame
//   start               : level, sampled every cycle in IDLE/GAMEOVER
//   p1_up/down, p2_up/down : synchronized paddle buttons
//   ball_x, ball_y      : ball top-left
//   paddle1_y, paddle2_y: paddle top rows
//   score1, score2      : saturating scores
//   game_state          : FSM state (IDLE/SERVE/PLAY/POINT/GAMEOVER)
//   frame_done          : pulses on the cycle the frame update lands
// An accepted frame_tick at cycle T moves paddles at T+1; ball, direction,
// score and state land at T+2 together with frame_done. Ticks seen while
// the update is in flight are dropped.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int H_ACTIVE     = H_ACTIVE_DEF,
  parameter int V_ACTIVE     = V_ACTIVE_DEF,
  parameter int BALL_SIZE    = BALL_SIZE_DEF,
  parameter int PADDLE_H     = PADDLE_H_DEF,
  parameter int PADDLE_W     = 8,
  parameter int PADDLE1_X    = 16,
  parameter int PADDLE2_X    = 616,
  parameter int PADDLE_STEP  = 4,
  parameter int BALL_STEP    = 2,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       p1_up,
  input  logic       p1_down,
  input  logic       p2_up,
  input  logic       p2_down,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [9:0] paddle1_y,
  output logic [9:0] paddle2_y,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [2:0] game_state,
  output logic       frame_done
);

  localparam int CW = cnt_width(SERVE_FRAMES);

  localparam logic [9:0] X_CTR   = 10'((H_ACTIVE - BALL_SIZE) / 2);
  localparam logic [9:0] Y_CTR   = 10'((V_ACTIVE - BALL_SIZE) / 2);
  localparam logic [9:0] X_RIGHT = 10'(H_ACTIVE - BALL_SIZE);
  localparam logic [9:0] Y_BOT   = 10'(V_ACTIVE - BALL_SIZE);
  localparam logic [9:0] STEP    = 10'(BALL_STEP);
  localparam logic [9:0] BS      = 10'(BALL_SIZE);
  localparam logic [9:0] PH      = 10'(PADDLE_H);
  localparam logic [9:0] P1_FACE = 10'(PADDLE1_X + PADDLE_W);
  localparam logic [9:0] P2_FACE = 10'(PADDLE2_X - BALL_SIZE);
  localparam logic [3:0] WIN     = 4'(WIN_SCORE);
  localparam logic [CW-1:0] SERVE_LAST = CW'(SERVE_FRAMES - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  game_state_t   state, state_n;
  dir_t          dx, dx_n, dy, dy_n;
  logic [9:0]    bx_n, by_n;
  logic [3:0]    s1_n, s2_n;
  logic [CW-1:0] serve_cnt, cnt_n;
  logic          busy;
  logic          tick_ok;
  logic          move_en;
  logic          p1_hit, p2_hit;

  // busy marks the second (ball) phase of an accepted frame update.
  assign tick_ok    = frame_tick && !busy;
  assign move_en    = tick_ok && (state == ST_SERVE || state == ST_PLAY);
  assign game_state = state;

  pong_paddle_mover #(
    .STEP(PADDLE_STEP), .Y_MAX(V_ACTIVE - PADDLE_H), .Y_RESET((V_ACTIVE - PADDLE_H) / 2)
  ) u_paddle1 (
    .clk(clk), .rst_n(rst_n), .move_en(move_en), .up(p1_up), .down(p1_down), .y(paddle1_y)
  );

  pong_paddle_mover #(
    .STEP(PADDLE_STEP), .Y_MAX(V_ACTIVE - PADDLE_H), .Y_RESET((V_ACTIVE - PADDLE_H) / 2)
  ) u_paddle2 (
    .clk(clk), .rst_n(rst_n), .move_en(move_en), .up(p2_up), .down(p2_down), .y(paddle2_y)
  );

  // Paddle registers already hold this frame's positions during the ball
  // phase. Face tests are written as additions so nothing underflows.
  assign p1_hit = (dx == DIR_NEG) && (ball_x >= P1_FACE) && (ball_x <= P1_FACE + STEP) &&
                  (ball_y + BS > paddle1_y) && (ball_y < paddle1_y + PH);
  assign p2_hit = (dx == DIR_POS) && (ball_x <= P2_FACE) && (ball_x + STEP >= P2_FACE) &&
                  (ball_y + BS > paddle2_y) && (ball_y < paddle2_y + PH);

  always_comb begin
    state_n = state;
    bx_n    = ball_x;
    by_n    = ball_y;
    dx_n    = dx;
    dy_n    = dy;
    s1_n    = score1;
    s2_n    = score2;
    cnt_n   = serve_cnt;
    case (state)
      ST_IDLE, ST_GAMEOVER: begin
        if (start) begin
          state_n = ST_SERVE;
          s1_n    = 4'd0;
          s2_n    = 4'd0;
          bx_n    = X_CTR;
          by_n    = Y_CTR;
          dx_n    = DIR_POS;
          dy_n    = DIR_POS;
          cnt_n   = '0;
        end
      end
      ST_SERVE: begin
        if (busy) begin
          if (serve_cnt == SERVE_LAST) begin
            state_n = ST_PLAY;
            cnt_n   = '0;
          end else begin
            cnt_n = serve_cnt + CNT_ONE;
          end
        end
      end
      ST_PLAY: begin
        if (busy) begin
          if (dy == DIR_NEG) begin
            if (ball_y < STEP) begin
              by_n = 10'd0;
              dy_n = DIR_POS;
            end else begin
              by_n = ball_y - STEP;
            end
          end else begin
            if (ball_y + STEP >= Y_BOT) begin
              by_n = Y_BOT;
              dy_n = DIR_NEG;
            end else begin
              by_n = ball_y + STEP;
            end
          end
          if (dx == DIR_NEG) begin
            if (p1_hit) begin
              bx_n = P1_FACE;
              dx_n = DIR_POS;
            end else if (ball_x < STEP) begin
              bx_n    = 10'd0;
              s2_n    = sat_inc(score2);
              state_n = ST_POINT;
            end else begin
              bx_n = ball_x - STEP;
            end
          end else begin
            if (p2_hit) begin
              bx_n = P2_FACE;
              dx_n = DIR_NEG;
            end else if (ball_x + STEP > X_RIGHT) begin
              bx_n    = X_RIGHT;
              s1_n    = sat_inc(score1);
              state_n = ST_POINT;
            end else begin
              bx_n = ball_x + STEP;
            end
          end
        end
      end
      ST_POINT: begin
        // dx still points at the player who conceded, so it also names the scorer.
        if (((dx == DIR_NEG) ? score2 : score1) == WIN) begin
          state_n = ST_GAMEOVER;
        end else begin
          state_n = ST_SERVE;
          bx_n    = X_CTR;
          by_n    = Y_CTR;
          dy_n    = DIR_POS;
          cnt_n   = '0;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      ball_x     <= X_CTR;
      ball_y     <= Y_CTR;
      dx         <= DIR_POS;
      dy         <= DIR_POS;
      score1     <= 4'd0;
      score2     <= 4'd0;
      serve_cnt  <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      ball_x     <= bx_n;
      ball_y     <= by_n;
      dx         <= dx_n;
      dy         <= dy_n;
      score1     <= s1_n;
      score2     <= s2_n;
      serve_cnt  <= cnt_n;
      busy       <= tick_ok;
      frame_done <= busy;
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: plays whole rallies from reset to game
// over and checks landmark frames against hand-derived trajectories.
module tb_pong_game_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_tick, start;
  logic       p1_up, p1_down, p2_up, p2_down;
  logic [9:0] ball_x, ball_y, paddle1_y, paddle2_y;
  logic [3:0] score1, score2;
  logic [2:0] game_state;
  logic       frame_done;

  int errors = 0;
  int checks = 0;
  int done_cnt;
  logic [2:0] st_t1;

  always #5 clk = ~clk;

  pong_game_ctrl dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .start(start),
    .p1_up(p1_up), .p1_down(p1_down), .p2_up(p2_up), .p2_down(p2_down),
    .ball_x(ball_x), .ball_y(ball_y), .paddle1_y(paddle1_y), .paddle2_y(paddle2_y),
    .score1(score1), .score2(score2), .game_state(game_state), .frame_done(frame_done)
  );

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One frame: tick in cycle T, returns sampled in cycle T+2.
  task automatic tick_frame();
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    st_t1 = game_state;
    @(posedge clk); #1;
    if (frame_done) done_cnt++;
  endtask

  task automatic run_frames(input int n);
    for (int i = 0; i < n; i++) tick_frame();
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; frame_tick = 1'b0; start = 1'b0;
    p1_up = 1'b0; p1_down = 1'b0; p2_up = 1'b0; p2_down = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({ball_x, ball_y} !== {10'd316, 10'd236}) begin errors++; $display("FAIL reset_ball: got (%0d,%0d) want (316,236)", ball_x, ball_y); end
    checks++; if ({paddle1_y, paddle2_y} !== {10'd208, 10'd208}) begin errors++; $display("FAIL reset_paddles: got (%0d,%0d) want (208,208)", paddle1_y, paddle2_y); end
    checks++; if ({score1, score2, game_state, frame_done} !== {4'd0, 4'd0, 3'd0, 1'b0}) begin errors++; $display("FAIL reset_misc: got s1=%0d s2=%0d st=%0d fd=%0d want 0 0 0 0", score1, score2, game_state, frame_done); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // A two-cycle tick: the second cycle lands while the update is in flight.
  task automatic test_idle_tick();
    int pulses;
    pulses = 0;
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1;
    if (frame_done) pulses++;
    @(posedge clk); #1 frame_tick = 1'b0;
    if (frame_done) pulses++;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (frame_done) pulses++;
    end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL idle_tick_done: got %0d pulses want 1", pulses); end
    checks++; if (game_state !== 3'd0) begin errors++; $display("FAIL idle_tick_state: got %0d want 0", game_state); end
    checks++; if ({ball_x, ball_y, paddle1_y} !== {10'd316, 10'd236, 10'd208}) begin errors++; $display("FAIL idle_tick_pos: got (%0d,%0d) p1=%0d want (316,236) 208", ball_x, ball_y, paddle1_y); end
  endtask

  task automatic test_serve();
    pulse_start();
    checks++; if (game_state !== 3'd1) begin errors++; $display("FAIL serve_enter: got state %0d want 1", game_state); end
    done_cnt = 0;
    p1_up = 1'b1; p2_up = 1'b1; p2_down = 1'b1;
    run_frames(51);
    checks++; if (paddle1_y !== 10'd4) begin errors++; $display("FAIL serve_p1_51: got %0d want 4", paddle1_y); end
    run_frames(1);
    checks++; if (paddle1_y !== 10'd0) begin errors++; $display("FAIL serve_p1_52: got %0d want 0", paddle1_y); end
    run_frames(7);
    checks++; if ({game_state, ball_x, ball_y} !== {3'd1, 10'd316, 10'd236}) begin errors++; $display("FAIL serve_59: got st=%0d (%0d,%0d) want 1 (316,236)", game_state, ball_x, ball_y); end
    run_frames(1);
    checks++; if (st_t1 !== 3'd1) begin errors++; $display("FAIL serve_60_t1: got state %0d want 1", st_t1); end
    checks++; if (game_state !== 3'd2) begin errors++; $display("FAIL serve_60_t2: got state %0d want 2", game_state); end
    checks++; if ({paddle1_y, paddle2_y} !== {10'd0, 10'd208}) begin errors++; $display("FAIL serve_paddles: got (%0d,%0d) want (0,208)", paddle1_y, paddle2_y); end
    checks++; if (done_cnt !== 60) begin errors++; $display("FAIL serve_done_cnt: got %0d want 60", done_cnt); end
    p1_up = 1'b0; p2_up = 1'b0; p2_down = 1'b0;
  endtask

  // Rally 1: centre, right/down, paddle 2 at 208 misses, player 1 scores.
  task automatic test_right_miss();
    run_frames(1);
    checks++; if ({ball_x, ball_y} !== {10'd318, 10'd238}) begin errors++; $display("FAIL r1_f1: got (%0d,%0d) want (318,238)", ball_x, ball_y); end
    run_frames(117);
    checks++; if ({ball_x, ball_y} !== {10'd552, 10'd472}) begin errors++; $display("FAIL r1_bottom: got (%0d,%0d) want (552,472)", ball_x, ball_y); end
    run_frames(1);
    checks++; if ({ball_x, ball_y} !== {10'd554, 10'd470}) begin errors++; $display("FAIL r1_bounce: got (%0d,%0d) want (554,470)", ball_x, ball_y); end
    run_frames(39);
    checks++; if ({game_state, ball_x, ball_y} !== {3'd2, 10'd632, 10'd392}) begin errors++; $display("FAIL r1_edge: got st=%0d (%0d,%0d) want 2 (632,392)", game_state, ball_x, ball_y); end
    run_frames(1);
    checks++; if ({game_state, score1, score2, ball_x, ball_y} !== {3'd3, 4'd1, 4'd0, 10'd632, 10'd390}) begin errors++; $display("FAIL r1_score: got st=%0d s=%0d:%0d (%0d,%0d) want 3 1:0 (632,390)", game_state, score1, score2, ball_x, ball_y); end
    @(posedge clk); #1;
    checks++; if ({game_state, ball_x, ball_y} !== {3'd1, 10'd316, 10'd236}) begin errors++; $display("FAIL r1_reserve: got st=%0d (%0d,%0d) want 1 (316,236)", game_state, ball_x, ball_y); end
  endtask

  // Rally 2: paddle 2 at 416 returns the ball, paddle 1 at 240 misses it.
  task automatic test_p2_hit_left_miss();
    p1_down = 1'b1; p2_down = 1'b1;
    run_frames(52);
    checks++; if (paddle2_y !== 10'd416) begin errors++; $display("FAIL s2_p2_clamp: got %0d want 416", paddle2_y); end
    run_frames(8);
    p1_down = 1'b0; p2_down = 1'b0;
    checks++; if ({game_state, paddle1_y, paddle2_y} !== {3'd2, 10'd240, 10'd416}) begin errors++; $display("FAIL s2_end: got st=%0d p=(%0d,%0d) want 2 (240,416)", game_state, paddle1_y, paddle2_y); end
    run_frames(145);
    checks++; if ({ball_x, ball_y} !== {10'd606, 10'd418}) begin errors++; $display("FAIL r2_f145: got (%0d,%0d) want (606,418)", ball_x, ball_y); end
    run_frames(1);
    checks++; if ({ball_x, ball_y} !== {10'd608, 10'd416}) begin errors++; $display("FAIL r2_p2_hit: got (%0d,%0d) want (608,416)", ball_x, ball_y); end
    run_frames(1);
    checks++; if ({ball_x, ball_y} !== {10'd606, 10'd414}) begin errors++; $display("FAIL r2_after_hit: got (%0d,%0d) want (606,414)", ball_x, ball_y); end
    run_frames(207);
    checks++; if ({ball_x, ball_y} !== {10'd192, 10'd0}) begin errors++; $display("FAIL r2_top: got (%0d,%0d) want (192,0)", ball_x, ball_y); end
    run_frames(1);
    checks++; if ({ball_x, ball_y} !== {10'd190, 10'd0}) begin errors++; $display("FAIL r2_top_clamp: got (%0d,%0d) want (190,0)", ball_x, ball_y); end
    run_frames(1);
    checks++; if ({ball_x, ball_y} !== {10'd188, 10'd2}) begin errors++; $display("FAIL r2_top_bounce: got (%0d,%0d) want (188,2)", ball_x, ball_y); end
    run_frames(82);
    checks++; if ({ball_x, ball_y, score2} !== {10'd24, 10'd166, 4'd0}) begin errors++; $display("FAIL r2_p1_miss: got (%0d,%0d) s2=%0d want (24,166) 0", ball_x, ball_y, score2); end
    run_frames(12);
    checks++; if ({game_state, ball_x, ball_y} !== {3'd2, 10'd0, 10'd190}) begin errors++; $display("FAIL r2_edge: got st=%0d (%0d,%0d) want 2 (0,190)", game_state, ball_x, ball_y); end
    run_frames(1);
    checks++; if ({game_state, score1, score2, ball_x, ball_y} !== {3'd3, 4'd1, 4'd1, 10'd0, 10'd192}) begin errors++; $display("FAIL r2_score: got st=%0d s=%0d:%0d (%0d,%0d) want 3 1:1 (0,192)", game_state, score1, score2, ball_x, ball_y); end
    @(posedge clk); #1;
    checks++; if ({game_state, ball_x, ball_y} !== {3'd1, 10'd316, 10'd236}) begin errors++; $display("FAIL r2_reserve: got st=%0d (%0d,%0d) want 1 (316,236)", game_state, ball_x, ball_y); end
  endtask

  // Rally 3: serve goes left toward the conceder; paddle 1 at 416 returns it,
  // then paddle 2 at 416 misses and player 1 scores.
  task automatic test_p1_hit();
    p1_down = 1'b1;
    run_frames(60);
    p1_down = 1'b0;
    checks++; if ({game_state, paddle1_y} !== {3'd2, 10'd416}) begin errors++; $display("FAIL s3_end: got st=%0d p1=%0d want 2 416", game_state, paddle1_y); end
    run_frames(1);
    checks++; if ({ball_x, ball_y} !== {10'd314, 10'd238}) begin errors++; $display("FAIL r3_serve_left: got (%0d,%0d) want (314,238)", ball_x, ball_y); end
    run_frames(144);
    checks++; if ({ball_x, ball_y} !== {10'd26, 10'd418}) begin errors++; $display("FAIL r3_f145: got (%0d,%0d) want (26,418)", ball_x, ball_y); end
    run_frames(1);
    checks++; if ({ball_x, ball_y, score1, score2} !== {10'd24, 10'd416, 4'd1, 4'd1}) begin errors++; $display("FAIL r3_p1_hit: got (%0d,%0d) s=%0d:%0d want (24,416) 1:1", ball_x, ball_y, score1, score2); end
    run_frames(1);
    checks++; if ({ball_x, ball_y} !== {10'd26, 10'd414}) begin errors++; $display("FAIL r3_after_hit: got (%0d,%0d) want (26,414)", ball_x, ball_y); end
    run_frames(304);
    checks++; if ({game_state, score1, score2, ball_x, ball_y} !== {3'd3, 4'd2, 4'd1, 10'd632, 10'd192}) begin errors++; $display("FAIL r3_score: got st=%0d s=%0d:%0d (%0d,%0d) want 3 2:1 (632,192)", game_state, score1, score2, ball_x, ball_y); end
    @(posedge clk); #1;
  endtask

  // Rallies 4..8: paddle 2 is driven up out of the way, player 1 wins 7:1.
  task automatic test_gameover();
    for (int r = 0; r < 5; r++) begin
      p2_up = 1'b1;
      run_frames(60);
      p2_up = 1'b0;
      if (r == 0) begin
        checks++; if (paddle2_y !== 10'd176) begin errors++; $display("FAIL s4_p2: got %0d want 176", paddle2_y); end
      end
      run_frames(159);
      checks++; if ({game_state, score1} !== {3'd3, 4'(3 + r)}) begin errors++; $display("FAIL rally%0d_score: got st=%0d s1=%0d want 3 %0d", r + 4, game_state, score1, 3 + r); end
      @(posedge clk); #1;
      checks++; if (game_state !== ((r == 4) ? 3'd4 : 3'd1)) begin errors++; $display("FAIL rally%0d_next: got st=%0d want %0d", r + 4, game_state, (r == 4) ? 4 : 1); end
    end
    done_cnt = 0;
    p1_up = 1'b1;
    run_frames(10);
    p1_up = 1'b0;
    checks++; if ({game_state, ball_x, ball_y, paddle1_y, paddle2_y} !== {3'd4, 10'd632, 10'd390, 10'd416, 10'd0}) begin errors++; $display("FAIL gameover_frozen: got st=%0d (%0d,%0d) p=(%0d,%0d) want 4 (632,390) (416,0)", game_state, ball_x, ball_y, paddle1_y, paddle2_y); end
    checks++; if ({score1, score2} !== {4'd7, 4'd1}) begin errors++; $display("FAIL gameover_scores: got %0d:%0d want 7:1", score1, score2); end
    checks++; if (done_cnt !== 10) begin errors++; $display("FAIL gameover_done: got %0d want 10", done_cnt); end
    pulse_start();
    checks++; if ({game_state, score1, score2, ball_x, ball_y} !== {3'd1, 4'd0, 4'd0, 10'd316, 10'd236}) begin errors++; $display("FAIL restart: got st=%0d s=%0d:%0d (%0d,%0d) want 1 0:0 (316,236)", game_state, score1, score2, ball_x, ball_y); end
  endtask

  task automatic test_reset_mid_update();
    int pulses;
    pulses = 0;
    p1_up = 1'b1;
    run_frames(3);
    checks++; if (paddle1_y !== 10'd404) begin errors++; $display("FAIL pre_reset_p1: got %0d want 404", paddle1_y); end
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    checks++; if (paddle1_y !== 10'd400) begin errors++; $display("FAIL mid_update_p1: got %0d want 400", paddle1_y); end
    rst_n = 1'b0;
    #1;
    checks++; if ({ball_x, ball_y, paddle1_y, paddle2_y} !== {10'd316, 10'd236, 10'd208, 10'd208}) begin errors++; $display("FAIL rst_pos: got (%0d,%0d) p=(%0d,%0d) want (316,236) (208,208)", ball_x, ball_y, paddle1_y, paddle2_y); end
    checks++; if ({game_state, score1, score2, frame_done} !== {3'd0, 4'd0, 4'd0, 1'b0}) begin errors++; $display("FAIL rst_misc: got st=%0d s=%0d:%0d fd=%0d want 0 0:0 0", game_state, score1, score2, frame_done); end
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (frame_done) pulses++;
    end
    p1_up = 1'b0;
    checks++; if ({pulses, game_state, paddle1_y} !== {32'd0, 3'd0, 10'd208}) begin errors++; $display("FAIL rst_after: got pulses=%0d st=%0d p1=%0d want 0 0 208", pulses, game_state, paddle1_y); end
  endtask

  initial begin
    test_reset();
    test_idle_tick();
    test_serve();
    test_right_miss();
    test_p2_hit_left_miss();
    test_p1_hit();
    test_gameover();
    test_reset_mid_update();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Frame-rate game controller for the pong design: once per video frame it sequences paddle movement, ball movement, wall/paddle collision resolution and scoring, and drives the position registers consumed by the ball and paddle renderers. It sits between the sync pulse generator, which supplies `frame_tick`, and the renderers, which read `ball_x/ball_y/paddle*_y`. A top-level FSM handles idle, serve delay, play, point and game-over.

## Interface
- `H_ACTIVE`, 640: visible columns.
- `V_ACTIVE`, 480: visible rows.
- `BALL_SIZE`, 8: ball square edge, px.
- `PADDLE_H`, 64 / `PADDLE_W`, 8: paddle size, px.
- `PADDLE1_X`, 16 / `PADDLE2_X`, 616: paddle left edges.
- `PADDLE_STEP`, 4 / `BALL_STEP`, 2: px moved per frame.
- `SERVE_FRAMES`, 60: frames ball is held before launch.
- `WIN_SCORE`, 7: score that ends the game.
- `clk  in  1`: the one clock; all logic is on this clock.
- `rst_n  in  1`: asynchronous active-low reset.
- `frame_tick  in  1`: one-cycle pulse per frame (start of vertical blank).
- `start  in  1`: level, sampled in IDLE/GAMEOVER.
- `p1_up, p1_down, p2_up, p2_down  in  1 each`: synchronized buttons.
- `ball_x, ball_y  out  10`: ball top-left.
- `paddle1_y, paddle2_y  out  10`: paddle top rows.
- `score1, score2  out  4`: scores.
- `game_state  out  3`: IDLE=0, SERVE=1, PLAY=2, POINT=3, GAMEOVER=4.
- `frame_done  out  1`: one-cycle pulse when the frame update completes.

## Operation
- Reset values: ball_x=316, ball_y=236 (centre), paddles=208, scores=0, IDLE, frame_done=0, direction right/down.
- IDLE: start=1 → scores cleared, ball centred → SERVE, serve direction right.
- SERVE: the ball is held at centre while the paddles move. After SERVE_FRAMES frame_ticks, the state goes to PLAY on the update of the last tick.
- PLAY, per frame:
  - Paddle phase: up&!down → y = (y ≥ STEP) ? y−STEP : 0.
  - down&!up → y = min(y+STEP, V_ACTIVE−PADDLE_H).
  - Both pressed or neither pressed → hold.
- Ball phase, applied to the x and y axes independently:
  - Walls:
    - Moving up with y < BALL_STEP → y=0, dy=down.
    - Moving down with y+BALL_STEP ≥ V_ACTIVE−BALL_SIZE → y=V_ACTIVE−BALL_SIZE, dy=up.
    - Otherwise y ± BALL_STEP.
  - Paddle 1 hit:
    - Condition: moving left, x ≥ PADDLE1_X+PADDLE_W, x−BALL_STEP ≤ PADDLE1_X+PADDLE_W, and vertical overlap (ball_y+BALL_SIZE > p1_y and ball_y < p1_y+PADDLE_H). The overlap test uses the paddle position updated this frame.
    - Effect: x = PADDLE1_X+PADDLE_W, dx=right.
  - Paddle 2 hit: mirrored, with face = PADDLE2_X−BALL_SIZE.
  - Score, when no paddle hit:
    - Moving left with x < BALL_STEP → score2++ → POINT.
    - Moving right with x+BALL_STEP > H_ACTIVE−BALL_SIZE → score1++ → POINT.
    - The ball is clamped to the edge.
  - A wall and a paddle in the same frame both apply.
- POINT, one cycle:
  - Scorer's score == WIN_SCORE → GAMEOVER.
  - Otherwise → SERVE, ball centred, serve counter cleared, dx toward the player who conceded.
- GAMEOVER: positions and scores frozen. start=1 → scores cleared → SERVE.
- Scores saturate at 15. Arithmetic is 10-bit unsigned. Every comparison is arranged so that no subtraction underflows.

## Timing
- `frame_tick` at cycle T:
  - Paddle registers update at T+1.
  - Ball, direction, score and state registers update at T+2.
  - frame_done=1 during T+2.
- Latency is fixed at 2 cycles in every state. In IDLE/GAMEOVER only frame_done pulses.
- A frame_tick arriving while an update is in flight (T+1) is ignored.
- start is sampled on any cycle in IDLE/GAMEOVER, independent of frame_tick.
- Outputs change only on the update edges. Renderers sample them during active video, so tearing cannot occur.
- Asserting rst_n low mid-update returns all outputs to reset values immediately. The update is abandoned.

## Structure
- `pong_pkg`: game_state enum, H_ACTIVE/V_ACTIVE defaults, centre-position constants, direction typedef.
- Sub-module `pong_paddle_mover`: one paddle's clamp/step logic, instantiated twice.
- Top FSM, serve counter (6 bits minimum, sized from SERVE_FRAMES) and update-phase sequencer stay in pong_game_ctrl.

## Test plan
- Reset, then start=1, then 60 frame_ticks → game_state goes 0→1→2 on the 60th tick's T+2, ball at (316,236), frame_done pulses every tick.
- SERVE with p1_up held for 60 ticks from y=208 → paddle1_y reaches 0 after 52 ticks and stays at 0. With both buttons held → no change.
- PLAY, ball (316,1) moving up-right → next ball_y=0, dy=down. Following frame → ball_y=2.
- Ball (26,230) moving left, paddle1_y=208 → ball_x=24, dx=right, no score change. Same with paddle1_y=0 → ball reaches x=0, score2=1, POINT, then SERVE with dx=left.
- score1=6 and a right-edge miss → score1=7, GAMEOVER, positions frozen across 10 ticks. start=1 → scores 0, SERVE.
- rst_n pulsed low one cycle after a frame_tick → outputs at reset values, state IDLE, no frame_done.
